// File: rtl/raptor64_rf_scoreboard.sv
// Register-file hazard scoreboard: stalls decode until sources and destination have no long-latency write in flight.
// Optional macro RAPTOR64_SB_CMPBYPASS_EN lets a same-cycle completion clear its hazard combinationally.
module raptor64_rf_scoreboard #(
  parameter int NREG   = 512,
  parameter int MAXOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_valid,
  input  logic                    d_long,
  input  logic [$clog2(NREG)-1:0] dRa,
  input  logic [$clog2(NREG)-1:0] dRb,
  input  logic [$clog2(NREG)-1:0] dRc,
  input  logic [$clog2(NREG)-1:0] dRt,
  input  logic                    advance_req,
  input  logic                    cmp_valid,
  input  logic [$clog2(NREG)-1:0] cmp_Rt,
  input  logic                    flush,
  output logic                    stall,
  output logic                    advanceR,
  output logic                    busy,
  output logic [3:0]              outstanding,
  output logic                    err_spurious
);

  localparam int AW = $clog2(NREG);
  localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);

  logic [NREG-1:0] pending_q, pending_d;
  logic [3:0]      outstanding_q, outstanding_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic hw_a, hw_b, hw_c, hw_t, hw_cmp;
  logic pend_a, pend_b, pend_c, pend_t;
  logic byp_a, byp_b, byp_c, byp_t;
  logic hazard, full, issue, cmp_hit, spurious;

  function automatic logic is_hw(input logic [AW-1:0] a);
    return (a[4:0] == 5'b00000) || (a[4:0] == 5'b11101);
  endfunction

  always_comb begin
    hw_a   = is_hw(dRa);
    hw_b   = is_hw(dRb);
    hw_c   = is_hw(dRc);
    hw_t   = is_hw(dRt);
    hw_cmp = is_hw(cmp_Rt);
  end

`ifdef RAPTOR64_SB_CMPBYPASS_EN
  // A register completing this cycle gets its data from the tData bypass, so it is not a hazard.
  always_comb begin
    byp_a = cmp_valid && (cmp_Rt == dRa);
    byp_b = cmp_valid && (cmp_Rt == dRb);
    byp_c = cmp_valid && (cmp_Rt == dRc);
    byp_t = cmp_valid && (cmp_Rt == dRt);
  end
`else
  always_comb begin
    byp_a = 1'b0;
    byp_b = 1'b0;
    byp_c = 1'b0;
    byp_t = 1'b0;
  end
`endif

  always_comb begin
    pend_a   = pending_q[dRa] & ~hw_a & ~byp_a;
    pend_b   = pending_q[dRb] & ~hw_b & ~byp_b;
    pend_c   = pending_q[dRc] & ~hw_c & ~byp_c;
    pend_t   = pending_q[dRt] & ~hw_t & ~byp_t;
    hazard   = pend_a | pend_b | pend_c | (pend_t & d_valid);
    full     = (outstanding_q == MAXOUT_C);
    stall    = d_valid & (hazard | (d_long & full));
    advanceR = advance_req & ~stall & ~flush;
    issue    = advanceR & d_valid & d_long & ~hw_t;
    cmp_hit  = cmp_valid & pending_q[cmp_Rt] & ~hw_cmp;
    spurious = cmp_valid & ~pending_q[cmp_Rt] & ~hw_cmp;
  end

  // Clear before set: with bypass a same-register issue re-arms the slot for the new write.
  always_comb begin
    pending_d = pending_q;
    if (cmp_hit) pending_d[cmp_Rt] = 1'b0;
    if (issue)   pending_d[dRt]    = 1'b1;

    outstanding_d = outstanding_q;
    unique case ({issue, cmp_hit})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    err_d  = err_q | spurious;
    busy_d = (outstanding_d != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    busy         = busy_q;
    outstanding  = outstanding_q;
    err_spurious = err_q;
  end

endmodule

// File: tb/tb_raptor64_rf_scoreboard.sv
// Directed scoreboard bench: stimulus queues expected {stall,advanceR,busy,outstanding,err}; a negedge monitor checks.
module tb_raptor64_rf_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid, d_long, advance_req, cmp_valid, flush;
  logic [8:0] dRa, dRb, dRc, dRt, cmp_Rt;
  logic       stall, advanceR, busy, err_spurious;
  logic [3:0] outstanding;

  raptor64_rf_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_long(d_long),
    .dRa(dRa), .dRb(dRb), .dRc(dRc), .dRt(dRt), .advance_req(advance_req),
    .cmp_valid(cmp_valid), .cmp_Rt(cmp_Rt), .flush(flush),
    .stall(stall), .advanceR(advanceR), .busy(busy),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       probe = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [7:0] E(input logic st, input logic adv, input logic bz,
                                   input logic [3:0] o, input logic er);
    return {st, adv, bz, o, er};
  endfunction

  // Monitor: whenever a probe cycle is presented, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (probe) begin
      logic [7:0] act, expv;
      string nm;
      act = {stall, advanceR, busy, outstanding, err_spurious};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL monitor: output presented with empty expectation queue, act=%b", act);
      end else begin
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (act !== expv) begin
          n_bad++;
          $display("FAIL %s: {stall,advR,busy,out,err} got %b_%b_%b_%0d_%b want %b_%b_%b_%0d_%b",
                   nm, act[7], act[6], act[5], act[4:1], act[0],
                   expv[7], expv[6], expv[5], expv[4:1], expv[0]);
        end
      end
    end
  end

  task automatic drv(input logic v, input logic lg, input logic [8:0] ra, input logic [8:0] rb,
                     input logic [8:0] rc, input logic [8:0] rt, input logic adv,
                     input logic cv, input logic [8:0] crt, input logic fl);
    d_valid = v; d_long = lg; dRa = ra; dRb = rb; dRc = rc; dRt = rt;
    advance_req = adv; cmp_valid = cv; cmp_Rt = crt; flush = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(input string nm, input logic [7:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    cyc("reset_state", E(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hardwired destinations never become pending; hardwired sources never stall.
    drv(1, 1, 0, 0, 0, 9'd0, 1, 0, 0, 0);     cyc("hw_issue_r0", E(0, 1, 0, 0, 0));
    drv(1, 1, 0, 0, 0, 9'd29, 1, 0, 0, 0);    cyc("hw_issue_r29", E(0, 1, 0, 0, 0));
    drv(1, 1, 0, 0, 0, 9'd61, 1, 0, 0, 0);    cyc("hw_issue_r61", E(0, 1, 0, 0, 0));
    drv(1, 0, 9'd0, 9'd29, 9'd61, 9'd32, 1, 0, 0, 0); cyc("hw_sources", E(0, 1, 0, 0, 0));
    idle();                                    cyc("hw_none_pending", E(0, 0, 0, 0, 0));

    // RAW: long write to r5, dependent instruction waits for completion.
    drv(1, 1, 9'd1, 9'd2, 9'd3, 9'd5, 1, 0, 0, 0); cyc("raw_issue", E(0, 1, 0, 0, 0));
    drv(1, 0, 9'd5, 9'd1, 9'd1, 9'd6, 1, 0, 0, 0);
    cyc("raw_stall_c1", E(1, 0, 1, 1, 0));
    cyc("raw_stall_c2", E(1, 0, 1, 1, 0));
    cyc("raw_stall_c3", E(1, 0, 1, 1, 0));
    cmp_valid = 1'b1; cmp_Rt = 9'd5;
`ifdef RAPTOR64_SB_CMPBYPASS_EN
    cyc("raw_cmp_cycle", E(0, 1, 1, 1, 0));
`else
    cyc("raw_cmp_cycle", E(1, 0, 1, 1, 0));
`endif
    cmp_valid = 1'b0;
    cyc("raw_released", E(0, 1, 0, 0, 0));
    idle();                                    cyc("raw_idle", E(0, 0, 0, 0, 0));

    // Fill all eight slots, then check full-stall, WAW-stall and release by one completion.
    for (int i = 1; i <= 8; i++) begin
      drv(1, 1, 0, 0, 0, 9'(i), 1, 0, 0, 0);
      cyc($sformatf("fill_r%0d", i), E(0, 1, i > 1, 4'(i - 1), 0));
    end
    drv(1, 1, 0, 0, 0, 9'd9, 1, 0, 0, 0);     cyc("full_stall_r9", E(1, 0, 1, 8, 0));
    drv(1, 0, 0, 0, 0, 9'd3, 1, 0, 0, 0);     cyc("waw_stall_r3", E(1, 0, 1, 8, 0));
    drv(1, 0, 9'd9, 0, 0, 9'd40, 1, 0, 0, 0); cyc("full_short_ok", E(0, 1, 1, 8, 0));
    drv(1, 1, 0, 0, 0, 9'd9, 1, 1, 9'd3, 0);  cyc("full_cmp_r3", E(1, 0, 1, 8, 0));
    drv(1, 1, 0, 0, 0, 9'd9, 1, 0, 0, 0);     cyc("r9_issues", E(0, 1, 1, 7, 0));
    drv(1, 0, 9'd9, 0, 0, 9'd40, 1, 0, 0, 0); cyc("r9_pending", E(1, 0, 1, 8, 0));
    drv(1, 0, 9'd3, 0, 0, 9'd40, 1, 0, 0, 0); cyc("r3_cleared", E(0, 1, 1, 8, 0));

    // Simultaneous issue r10 and completion r4.
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9'd1, 0);     cyc("cmp_r1", E(0, 0, 1, 8, 0));
    drv(1, 1, 0, 0, 0, 9'd10, 1, 1, 9'd4, 0); cyc("sim_issue_cmp", E(0, 1, 1, 7, 0));
    drv(1, 0, 0, 0, 9'd10, 9'd40, 1, 0, 0, 0); cyc("sim_r10_pending", E(1, 0, 1, 7, 0));
    drv(1, 0, 0, 9'd4, 0, 9'd40, 1, 0, 0, 0); cyc("sim_r4_cleared", E(0, 1, 1, 7, 0));

    // Spurious completions and flush.
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9'd29, 0);    cyc("cmp_hw_r29", E(0, 0, 1, 7, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9'd12, 0);    cyc("cmp_spur_r12", E(0, 0, 1, 7, 0));
    idle();                                    cyc("err_sticky", E(0, 0, 1, 7, 1));
    drv(1, 1, 0, 0, 0, 9'd11, 1, 0, 0, 1);    cyc("flush_blocks", E(0, 0, 1, 7, 1));
    drv(1, 0, 0, 9'd10, 0, 9'd40, 1, 0, 0, 0); cyc("flush_kept_r10", E(1, 0, 1, 7, 1));
    drv(1, 0, 9'd11, 0, 0, 9'd40, 1, 0, 0, 0); cyc("flush_no_r11", E(0, 1, 1, 7, 1));

    // Asynchronous reset mid-cycle with writes outstanding.
    drv(1, 0, 9'd10, 0, 0, 9'd40, 1, 0, 0, 0);
    rst_n = 1'b0;
    cyc("async_reset", E(0, 1, 0, 0, 0));
    idle();
    cyc("reset_idle", E(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    drv(1, 1, 0, 0, 0, 9'd7, 1, 0, 0, 0);     cyc("post_reset_issue", E(0, 1, 0, 0, 0));
    idle();                                    cyc("post_reset_count", E(0, 0, 1, 1, 0));

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
